// File: rtl/sink_rand_if.sv
// Byte-stream handshake bundle: valid/ready/last plus data.
// The source drives valid/last/data, the sink answers with ready.
interface sink_rand_if #(
  parameter int LEN = 8
);
  logic           valid;
  logic           last;
  logic [LEN-1:0] data;
  logic           ready;

  modport master (
    output valid,
    output last,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  last,
    input  data,
    output ready
  );
endinterface

// File: rtl/sink_rand.sv
// Stream sink with LFSR-driven random backpressure.
// Accepts beats, accumulates per-packet sums and beat/packet counts,
// and raises a sticky error when the source breaks the rule that a
// pending beat must stay valid and stable until it is accepted.
module sink_rand #(
  parameter int          LEN     = 8,
  parameter int          DELAY_W = 3,
  parameter int          CNT_W   = 16,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  sink_rand_if.slave       s,
  input  logic             bp_en,
  output logic [LEN-1:0]   beat_out,
  output logic             beat_vld,
  output logic             pkt_done,
  output logic [LEN-1:0]   pkt_sum,
  output logic [CNT_W-1:0] beat_cnt,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic             err
);

  // A zero seed would lock the LFSR at zero forever.
  localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic {
    ST_WAIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [DELAY_W-1:0] wait_cnt_reg;
  logic [DELAY_W-1:0] wait_cnt_next;

  logic [15:0]        lfsr_reg;
  logic [15:0]        lfsr_next;
  logic [DELAY_W-1:0] stall_len;

  logic               ready_reg;
  logic               fire;

  logic [LEN-1:0]     acc_reg;
  logic [LEN-1:0]     beat_out_reg;
  logic               beat_vld_reg;
  logic               pkt_done_reg;
  logic [LEN-1:0]     pkt_sum_reg;
  logic [CNT_W-1:0]   beat_cnt_reg;
  logic [CNT_W-1:0]   pkt_cnt_reg;

  logic               pend_reg;
  logic [LEN-1:0]     pend_data_reg;
  logic               pend_last_reg;
  logic               err_reg;
  logic               violation;

  // ---------------------------------------------------------------
  // Galois LFSR, right shift: bit 0 falls out and, when set, is
  // folded back into the tap positions of the mask.
  // ---------------------------------------------------------------
  for (genvar gi = 0; gi < 16; gi++) begin : g_lfsr
    if (gi == 15) begin : g_top
      assign lfsr_next[gi] = LFSR_MASK[gi] & lfsr_reg[0];
    end else begin : g_mid
      assign lfsr_next[gi] = lfsr_reg[gi+1] ^ (LFSR_MASK[gi] & lfsr_reg[0]);
    end
  end

  // The stall length is whatever the LFSR holds in the accepting cycle.
  assign stall_len = lfsr_reg[DELAY_W-1:0];

  // ready comes straight from the state register, so it is glitch-free.
  assign ready_reg = (state_reg == ST_READY);
  assign s.ready   = ready_reg;
  assign fire      = s.valid && ready_reg;

  // LFSR advances on every cycle outside reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_reg <= SEED_EFF;
    end else begin
      lfsr_reg <= lfsr_next;
    end
  end

  // Backpressure FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_WAIT;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  // Next state: a fire with a non-zero stall parks us in WAIT for
  // exactly stall_len cycles (count runs stall_len-1 down to 0).
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      ST_WAIT: begin
        if (wait_cnt_reg == '0) begin
          state_next = ST_READY;
        end else begin
          wait_cnt_next = wait_cnt_reg - DELAY_W'(1);
        end
      end
      ST_READY: begin
        if (fire && bp_en && (stall_len != '0)) begin
          wait_cnt_next = stall_len - DELAY_W'(1);
          state_next    = ST_WAIT;
        end
      end
      default: begin
        state_next    = ST_WAIT;
        wait_cnt_next = '0;
      end
    endcase
  end

  // Beat capture, packet accumulation and counters; a last beat closes
  // the packet and clears the accumulator for the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg      <= '0;
      beat_out_reg <= '0;
      beat_vld_reg <= 1'b0;
      pkt_done_reg <= 1'b0;
      pkt_sum_reg  <= '0;
      beat_cnt_reg <= '0;
      pkt_cnt_reg  <= '0;
    end else begin
      beat_vld_reg <= fire;
      pkt_done_reg <= fire && s.last;
      if (fire) begin
        beat_out_reg <= s.data;
        beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
        if (s.last) begin
          pkt_sum_reg <= acc_reg + s.data;
          acc_reg     <= '0;
          pkt_cnt_reg <= pkt_cnt_reg + CNT_W'(1);
        end else begin
          acc_reg <= acc_reg + s.data;
        end
      end
    end
  end

  // A beat left pending must reappear unchanged in the following cycle.
  assign violation = pend_reg &&
                     (!s.valid || (s.data != pend_data_reg) || (s.last != pend_last_reg));

  // Protocol history and sticky error; errors never block acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_reg      <= 1'b0;
      pend_data_reg <= '0;
      pend_last_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      pend_reg      <= s.valid && !ready_reg;
      pend_data_reg <= s.data;
      pend_last_reg <= s.last;
      if (violation) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign beat_out = beat_out_reg;
  assign beat_vld = beat_vld_reg;
  assign pkt_done = pkt_done_reg;
  assign pkt_sum  = pkt_sum_reg;
  assign beat_cnt = beat_cnt_reg;
  assign pkt_cnt  = pkt_cnt_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_sink_rand.sv
// Randomized bench for sink_rand. A cycle-level reference model tracks
// the expected ready pattern, captures, sums, counters and error flag.
// A second instance with 4-bit counters shares the stimulus to exercise
// counter wrap.
module tb_sink_rand;

  localparam int          LEN     = 8;
  localparam int          DELAY_W = 3;
  localparam logic [15:0] SEED    = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic       last = 1'b0;
  logic [7:0] data = 8'h00;
  logic       bp_en = 1'b0;

  always #5 clk = ~clk;

  sink_rand_if #(.LEN(LEN)) sif ();
  sink_rand_if #(.LEN(LEN)) sif4 ();

  assign sif.valid  = valid;
  assign sif.last   = last;
  assign sif.data   = data;
  assign sif4.valid = valid;
  assign sif4.last  = last;
  assign sif4.data  = data;

  logic [7:0]  beat_out, pkt_sum, beat_out4, pkt_sum4;
  logic        beat_vld, pkt_done, err, beat_vld4, pkt_done4, err4;
  logic [15:0] beat_cnt, pkt_cnt;
  logic [3:0]  beat_cnt4, pkt_cnt4;

  sink_rand #(.LEN(LEN), .DELAY_W(DELAY_W), .CNT_W(16), .SEED(SEED)) u_dut (
    .clk(clk), .rst(rst), .s(sif), .bp_en(bp_en),
    .beat_out(beat_out), .beat_vld(beat_vld), .pkt_done(pkt_done),
    .pkt_sum(pkt_sum), .beat_cnt(beat_cnt), .pkt_cnt(pkt_cnt), .err(err)
  );

  sink_rand #(.LEN(LEN), .DELAY_W(DELAY_W), .CNT_W(4), .SEED(SEED)) u_dut4 (
    .clk(clk), .rst(rst), .s(sif4), .bp_en(bp_en),
    .beat_out(beat_out4), .beat_vld(beat_vld4), .pkt_done(pkt_done4),
    .pkt_sum(pkt_sum4), .beat_cnt(beat_cnt4), .pkt_cnt(pkt_cnt4), .err(err4)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [15:0] m_lfsr;
  int          m_stall;      // remaining cycles with ready low
  logic [7:0]  m_acc, m_pkt_sum, m_beat_out;
  int          m_beat_cnt, m_pkt_cnt;
  bit          m_beat_vld, m_pkt_done, m_err, m_fire;
  bit          m_pend;
  logic [7:0]  m_pend_data;
  bit          m_pend_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  // One clock cycle: predict the edge from current inputs, then compare.
  task automatic tick();
    bit         rdy;
    bit         viol;
    logic [2:0] d;
    rdy = (m_stall == 0);
    @(posedge clk);
    m_fire = 1'b0;
    if (rst) begin
      m_lfsr = SEED; m_stall = 1; m_acc = 0; m_pkt_sum = 0; m_beat_out = 0;
      m_beat_cnt = 0; m_pkt_cnt = 0; m_beat_vld = 0; m_pkt_done = 0;
      m_err = 0; m_pend = 0; m_pend_data = 0; m_pend_last = 0;
    end else begin
      m_fire = valid && rdy;
      d = m_lfsr[DELAY_W-1:0];
      viol = m_pend && (!valid || data != m_pend_data || last != m_pend_last);
      if (viol) m_err = 1'b1;
      m_pend = valid && !rdy;
      m_pend_data = data;
      m_pend_last = last;
      m_beat_vld = m_fire;
      m_pkt_done = m_fire && last;
      if (m_fire) begin
        m_beat_out = data;
        m_beat_cnt++;
        if (last) begin
          m_pkt_sum = 8'(m_acc + data);
          m_acc = 0;
          m_pkt_cnt++;
          $display("pkt %0d sum=%02h beats=%0d", m_pkt_cnt, m_pkt_sum, m_beat_cnt);
        end else begin
          m_acc = 8'(m_acc + data);
        end
      end
      if (m_stall > 0) m_stall--;
      else if (m_fire && bp_en && d != 0) m_stall = int'(d);
      m_lfsr = lfsr_step(m_lfsr);
    end
    #1;
    check("ready",    32'(sif.ready), 32'(m_stall == 0));
    check("beat_vld", 32'(beat_vld), 32'(m_beat_vld));
    check("beat_out", 32'(beat_out), 32'(m_beat_out));
    check("pkt_done", 32'(pkt_done), 32'(m_pkt_done));
    check("pkt_sum",  32'(pkt_sum),  32'(m_pkt_sum));
    check("beat_cnt", 32'(beat_cnt), 32'(m_beat_cnt % 65536));
    check("pkt_cnt",  32'(pkt_cnt),  32'(m_pkt_cnt % 65536));
    check("err",      32'(err),      32'(m_err));
    check("ready4",   32'(sif4.ready), 32'(m_stall == 0));
    check("beat_cnt4", 32'(beat_cnt4), 32'(m_beat_cnt % 16));
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0; last = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Compliant source: idle gap, then hold the beat until it is accepted.
  task automatic send_beat(input logic [7:0] d, input bit l, input int idle, input bit rand_bp);
    int n;
    for (int i = 0; i < idle; i++) begin
      valid = 1'b0; data = 8'($urandom); last = 1'($urandom);
      if (rand_bp) bp_en = 1'($urandom);
      tick();
    end
    valid = 1'b1; data = d; last = l; n = 0;
    do begin
      if (rand_bp) bp_en = 1'($urandom);
      tick();
      n++;
    end while (!m_fire && n < 64);
    if (!m_fire) check("fire_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic packet 1..4 with ready held high.
    do_reset();
    bp_en = 1'b0;
    for (int i = 1; i <= 4; i++) send_beat(8'(i), i == 4, 0, 1'b0);
    valid = 1'b0; tick();
    check("t1_pkt_sum", 32'(pkt_sum), 32'd10);
    check("t1_beat_cnt", 32'(beat_cnt), 32'd4);
    check("t1_pkt_cnt", 32'(pkt_cnt), 32'd1);

    // 100 single-beat packets under random backpressure.
    do_reset();
    bp_en = 1'b1;
    for (int i = 0; i < 100; i++) send_beat(8'h5A, 1'b1, $urandom_range(0, 3), 1'b0);
    valid = 1'b0; tick();
    check("t2_pkt_cnt", 32'(pkt_cnt), 32'd100);
    check("t2_pkt_sum", 32'(pkt_sum), 32'h5A);
    check("t2_err", 32'(err), 32'd0);

    // Sum wrap, then accumulator cleared.
    send_beat(8'hFF, 1'b0, 1, 1'b0);
    send_beat(8'h02, 1'b1, 0, 1'b0);
    valid = 1'b0; tick();
    check("t3_wrap", 32'(pkt_sum), 32'h01);
    send_beat(8'h07, 1'b1, 2, 1'b0);
    valid = 1'b0; tick();
    check("t3_clear", 32'(pkt_sum), 32'h07);

    // Random packets, bp_en toggling every cycle.
    for (int i = 0; i < 150; i++)
      send_beat(8'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 2), 1'b1);
    valid = 1'b0; tick();
    check("t4_err", 32'(err), 32'd0);

    // Data changed while pending: sticky error through compliant traffic.
    do_reset();
    bp_en = 1'b0;
    valid = 1'b1; data = 8'h33; last = 1'b0; tick();
    data = 8'h34; tick();
    check("t5_err_set", 32'(err), 32'd1);
    valid = 1'b0;
    for (int i = 0; i < 10; i++) send_beat(8'($urandom), 1'($urandom), 1, 1'b1);
    valid = 1'b0; tick();
    check("t5_err_sticky", 32'(err), 32'd1);
    do_reset();
    tick();
    check("t5_err_cleared", 32'(err), 32'd0);

    // Valid dropped while pending, in the cycle ready rises.
    do_reset();
    valid = 1'b1; data = 8'h44; last = 1'b1; tick();
    valid = 1'b0; tick();
    check("t6_err_drop", 32'(err), 32'd1);

    // Reset mid-packet discards the partial sum.
    do_reset();
    bp_en = 1'b1;
    send_beat(8'h08, 1'b0, 0, 1'b0);
    send_beat(8'h08, 1'b0, 0, 1'b0);
    do_reset();
    send_beat(8'h05, 1'b1, 0, 1'b0);
    valid = 1'b0; tick();
    check("t7_pkt_sum", 32'(pkt_sum), 32'h05);
    check("t7_beat_cnt", 32'(beat_cnt), 32'd1);
    check("t7_pkt_cnt", 32'(pkt_cnt), 32'd1);

    // 17 accepts: the 4-bit beat counter wraps to 1.
    do_reset();
    bp_en = 1'b0;
    for (int i = 0; i < 17; i++) send_beat(8'(i), 1'b0, 0, 1'b0);
    valid = 1'b0; tick();
    check("t8_cnt4_wrap", 32'(beat_cnt4), 32'd1);
    check("t8_cnt16", 32'(beat_cnt), 32'd17);
    check("t8_err4", 32'(err4), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sink_rand.md
Name: sink_rand

Overview:
- Receiving end of the valid/ready/last byte stream produced by the team's random-delay stream source.
- Consumes beats with pseudo-random backpressure, taken from an internal synthesizable LFSR instead of `$random`.
- Accumulates per-packet sum and beat/packet counts.
- Flags any source-side handshake violation.
- Used as the DUT-side sink in stream testbenches and as a standalone protocol checker.

Parameters:
- LEN, 8, data width in bits.
- DELAY_W, 3, width of random stall length; stall is 0..2^DELAY_W-1 cycles.
- CNT_W, 16, width of beat and packet counters.
- SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'hACE1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- valid  in  1  source beat valid.
- last  in  1  source end-of-packet marker, qualified by valid.
- data  in  LEN  source beat data.
- bp_en  in  1  1 = random backpressure; 0 = ready held high in READY state.
- ready  out  1  sink ready (registered).
- beat_out  out  LEN  data of the last accepted beat.
- beat_vld  out  1  one-cycle pulse, the cycle after each accept.
- pkt_done  out  1  one-cycle pulse, the cycle after accepting a beat with last=1.
- pkt_sum  out  LEN  sum mod 2^LEN of all beats of the most recent completed packet.
- beat_cnt  out  CNT_W  accepted beats since reset, wraps.
- pkt_cnt  out  CNT_W  completed packets since reset, wraps.
- err  out  1  sticky protocol-violation flag.

Behaviour:
- Accept ("fire") = valid && ready, sampled on the rising clk edge.
- Reset: rst=1 at an edge sets all outputs to 0, the LFSR to SEED, the state to WAIT with wait_cnt=0, the packet accumulator to 0, and the protocol history to "no pending beat". Reset mid-packet discards the partial sum.
- LFSR: 16-bit Galois, right shift, feedback mask 16'hB400. Advances every non-reset cycle. Stall length d = lfsr[DELAY_W-1:0], sampled in the fire cycle.
- WAIT state: ready=0. When wait_cnt==0, go to READY (ready=1 after the edge); otherwise wait_cnt decrements.
- READY state: ready=1. On fire:
  - if bp_en=0 or d==0, stay in READY (back-to-back accepts allowed);
  - otherwise wait_cnt<=d-1 and go to WAIT, giving exactly d cycles of ready=0.
- After reset release, ready rises one edge later: first cycle low, second cycle high.
- Capture on fire (all results visible the next cycle):
  - beat_out<=data, beat_vld<=1, beat_cnt<=beat_cnt+1.
  - acc<=acc+data mod 2^LEN.
- Last beat: if last=1 on fire, then pkt_sum<=acc+data, acc<=0, pkt_cnt<=pkt_cnt+1, pkt_done<=1. A single-beat packet gives pkt_sum=data.
- beat_vld and pkt_done are 0 in all other cycles.
- last with valid=0 is ignored.
- Counters wrap from all-ones to 0 without any flag.
- Protocol check: when a cycle ends with valid=1 and ready=0 (pending beat), the next cycle must have valid=1 with data and last unchanged. Otherwise err<=1.
- err stays set until rst; detection does not stop acceptance.
- Simultaneous events: a valid drop in the same cycle ready rises is still a violation. Fire and violation detection may coincide; both take effect.
- bp_en changing mid-stall does not shorten the current WAIT; it applies from the next fire.

Test Plan:
- Reset, bp_en=0, valid=1 held, data 1,2,3,4, last on 4:
  - ready=0 in cycle 0 after reset, then 1 continuously;
  - four beat_vld pulses with beat_out 1..4;
  - pkt_done once, pkt_sum=10, beat_cnt=4, pkt_cnt=1, err=0.
- bp_en=1, SEED=16'hACE1, 100 single-beat packets with data=8'h5A from a compliant random-delay source:
  - every stall length equals the model LFSR d;
  - pkt_cnt=100, all pkt_sum=8'h5A, err=0.
- Packet of beats 8'hFF, 8'h02, last on 2nd:
  - pkt_sum=8'h01 (wrap).
  - A following single-beat packet 8'h07 gives pkt_sum=8'h07 (accumulator cleared).
- Violation: hold valid=1, data=8'h33 while ready=0, then change data to 8'h34 before fire:
  - err=1 the next cycle and stays 1 through later compliant traffic;
  - only rst clears it.
- Violation: valid 1→0 while ready=0:
  - err=1.
- Assert rst after 2 beats of a packet (sum 8'h10), then send single beat 8'h05 with last:
  - pkt_sum=8'h05, beat_cnt=1, pkt_cnt=1.
- Force beat_cnt near wrap (CNT_W=4 build), 17 accepts:
  - beat_cnt=1, no err.
